prf_free_list: RTL and testbench

- Allocator for physical register file (PRF) tags: tracks which PRF entries are free.
- Hands one free tag per cycle to the rename stage.
- Reclaims tags released at retirement (the retired instruction's previous mapping, old_wb).
- Sits beside the PRF; its release input is driven by the same retire_ena/old_wb pair that clears the PRF ready bit.

---
 rtl/prf_free_list.sv | 117 +++++++++++
 tb/tb_prf_free_list.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prf_free_list.sv
// prf_free_list: free list of physical register file tags.
// A circular FIFO of free tags, with a free_mask bitvector kept in lockstep.
// One tag is granted per cycle (zero latency: the tag is presented
// combinationally and consumed at the clock edge where it is requested).
// One tag is reclaimed per cycle from retirement (old_wb).
// Releases of a tag that is already free, or into a full FIFO, are dropped
// and set the sticky err_double_free flag.
// Optional build macro FREELIST_BYPASS_EN: when the list is empty, a valid
// release is forwarded combinationally to the allocation port in the same cycle.
module prf_free_list #(
    parameter int PRF_SIZE  = 16,
    parameter int ARCH_REGS = 4,
    parameter int TAG_W     = $clog2(PRF_SIZE),
    parameter int CNT_W     = $clog2(PRF_SIZE) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alloc_req,
    output logic                alloc_valid,
    output logic [TAG_W-1:0]    alloc_tag,
    input  logic                release_ena,
    input  logic [TAG_W-1:0]    release_tag,
    output logic [CNT_W-1:0]    free_count,
    output logic [PRF_SIZE-1:0] free_mask,
    output logic                empty,
    output logic                err_double_free
);

    // Tags ARCH_REGS..PRF_SIZE-1 start free; 0..ARCH_REGS-1 hold the
    // architectural mappings at reset.
    localparam int INIT_FREE = PRF_SIZE - ARCH_REGS;

    logic [TAG_W-1:0]    fifo_q [PRF_SIZE];
    logic [TAG_W-1:0]    head_q, head_d;
    logic [TAG_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PRF_SIZE-1:0] mask_q, mask_d;
    logic                err_q, err_d;

    logic have_free;
    logic rel_ok;
    logic bypass;
    logic pop;
    logic push;

    // Release qualification, allocation handshake and optional empty-list bypass.
    always_comb begin
        have_free = (count_q != '0);
        rel_ok    = release_ena && !mask_q[release_tag] &&
                    (count_q != CNT_W'(PRF_SIZE));
`ifdef FREELIST_BYPASS_EN
        bypass    = !have_free && release_ena && !mask_q[release_tag];
`else
        bypass    = 1'b0;
`endif
        pop       = alloc_req && have_free;
        // A bypassed tag that is taken in the same cycle never enters the FIFO.
        push      = rel_ok && !(bypass && alloc_req);
    end

    // Allocation port and status outputs, driven from registered state
    // (plus the release port only when the bypass build is enabled).
    always_comb begin
        alloc_valid     = have_free || bypass;
        alloc_tag       = '0;
        if (have_free) begin
            alloc_tag = fifo_q[head_q];
        end else if (bypass) begin
            alloc_tag = release_tag;
        end
        free_count      = count_q;
        free_mask       = mask_q;
        empty           = !have_free;
        err_double_free = err_q;
    end

    // Next-state for pointers, count, mask and error flag.
    always_comb begin
        head_d  = pop  ? head_q + TAG_W'(1) : head_q;
        tail_d  = push ? tail_q + TAG_W'(1) : tail_q;
        count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
        mask_d  = mask_q;
        // The popped tag is still marked free, while a pushed tag is not, so
        // these two updates never touch the same bit.
        if (pop) begin
            mask_d[fifo_q[head_q]] = 1'b0;
        end
        if (push) begin
            mask_d[release_tag] = 1'b1;
        end
        err_d   = err_q || (release_ena && !rel_ok);
    end

    // State registers with asynchronous reset to the architectural-mapping image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PRF_SIZE; i++) begin
                fifo_q[i] <= (i < INIT_FREE) ? TAG_W'(ARCH_REGS + i) : '0;
            end
            head_q  <= '0;
            tail_q  <= TAG_W'(INIT_FREE);
            count_q <= CNT_W'(INIT_FREE);
            mask_q  <= {{INIT_FREE{1'b1}}, {ARCH_REGS{1'b0}}};
            err_q   <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[tail_q] <= release_tag;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mask_q  <= mask_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_prf_free_list.sv
// Testbench for prf_free_list (16 tags, 4 architectural).
// Reference model: a queue of free tags plus a per-tag "free" bit and an error flag.
module tb_prf_free_list;

    localparam int PRF_SIZE  = 16;
    localparam int ARCH_REGS = 4;
    localparam int TAG_W     = 4;
    localparam int CNT_W     = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                alloc_req;
    logic                alloc_valid;
    logic [TAG_W-1:0]    alloc_tag;
    logic                release_ena;
    logic [TAG_W-1:0]    release_tag;
    logic [CNT_W-1:0]    free_count;
    logic [PRF_SIZE-1:0] free_mask;
    logic                empty;
    logic                err_double_free;

    prf_free_list #(.PRF_SIZE(PRF_SIZE), .ARCH_REGS(ARCH_REGS)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .release_ena(release_ena), .release_tag(release_tag),
        .free_count(free_count), .free_mask(free_mask),
        .empty(empty), .err_double_free(err_double_free)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    int                  mq[$];
    logic [PRF_SIZE-1:0] mfree;
    logic                merr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic void model_reset();
        mq.delete();
        for (int i = ARCH_REGS; i < PRF_SIZE; i++) mq.push_back(i);
        mfree = '0;
        for (int i = ARCH_REGS; i < PRF_SIZE; i++) mfree[i] = 1'b1;
        merr = 1'b0;
    endfunction

    function automatic logic model_bypass(input logic ena, input logic [TAG_W-1:0] tag);
`ifdef FREELIST_BYPASS_EN
        return (mq.size() == 0) && ena && !mfree[tag];
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_edge(input logic req, input logic ena, input logic [TAG_W-1:0] tag);
        logic ok, byp;
        int t;
        byp = model_bypass(ena, tag);
        ok  = ena && !mfree[tag] && (mq.size() != PRF_SIZE);
        if (req && mq.size() != 0) begin
            t = mq.pop_front();
            mfree[t] = 1'b0;
        end
        if (ok && !(byp && req)) begin
            mq.push_back(int'(tag));
            mfree[tag] = 1'b1;
        end
        if (ena && !ok) merr = 1'b1;
    endfunction

    // Compare every DUT output against the model for the current cycle.
    task automatic check_outputs();
        logic byp;
        int   exp_tag;
        byp     = model_bypass(release_ena, release_tag);
        exp_tag = (mq.size() != 0) ? mq[0] : (byp ? int'(release_tag) : 0);
        chk("alloc_valid", alloc_valid, (mq.size() != 0) || byp);
        chk("alloc_tag", alloc_tag, exp_tag);
        chk("free_count", free_count, mq.size());
        chk("free_mask", free_mask, mfree);
        chk("empty", empty, mq.size() == 0);
        chk("err_double_free", err_double_free, merr);
        chk("popcount", $countones(free_mask), free_count);
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance model at the edge.
    task automatic step(input logic req, input logic ena, input logic [TAG_W-1:0] tag);
        alloc_req   = req;
        release_ena = ena;
        release_tag = tag;
        #1;
        check_outputs();
        @(posedge clk);
        model_edge(req, ena, tag);
        #1;
    endtask

    function automatic int pick_used();
        int cand[$];
        for (int i = 0; i < PRF_SIZE; i++) if (!mfree[i]) cand.push_back(i);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    // Assert reset between clock edges and confirm outputs change without an edge.
    task automatic async_reset(input string tag);
        alloc_req   = 1'b1;
        release_ena = 1'b1;
        release_tag = 4'd3;
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_cnt"}, free_count, 12);
        chk({tag, "_mask"}, free_mask, 16'hFFF0);
        chk({tag, "_valid"}, alloc_valid, 1);
        chk({tag, "_tag"}, alloc_tag, 4);
        chk({tag, "_err"}, err_double_free, 0);
        model_reset();
        alloc_req   = 1'b0;
        release_ena = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst_n       = 1'b0;
        alloc_req   = 1'b0;
        release_ena = 1'b0;
        release_tag = '0;
        model_reset();
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset defaults
        chk("rst_cnt", free_count, 12);
        chk("rst_mask", free_mask, 16'hFFF0);
        chk("rst_valid", alloc_valid, 1);
        chk("rst_tag", alloc_tag, 4);
        chk("rst_err", err_double_free, 0);

        // Drain: tags 4..15 in order, then a 13th request does nothing
        for (int i = 0; i < 12; i++) begin
            alloc_req = 1'b1;
            #1;
            chk("drain_tag", alloc_tag, 4 + i);
            step(1'b1, 1'b0, '0);
        end
        step(1'b1, 1'b0, '0);
        chk("drain_empty", empty, 1);
        chk("drain_mask", free_mask, 0);
        chk("drain_tag0", alloc_tag, 0);

`ifdef FREELIST_BYPASS_EN
        // Bypass: released tag passes straight to the allocator
        alloc_req = 1'b1; release_ena = 1'b1; release_tag = 4'd5;
        #1;
        chk("byp_tag", alloc_tag, 5);
        chk("byp_valid", alloc_valid, 1);
        step(1'b1, 1'b1, 4'd5);
        chk("byp_cnt", free_count, 0);
        chk("byp_mask", free_mask, 0);
`endif

        // Release 7 then 2 from empty, then reuse in order
        release_ena = 1'b1; release_tag = 4'd7; alloc_req = 1'b0;
        #1;
`ifndef FREELIST_BYPASS_EN
        chk("norel_bypass", alloc_valid, 0);
`endif
        step(1'b0, 1'b1, 4'd7);
        step(1'b0, 1'b1, 4'd2);
        chk("rel_cnt", free_count, 2);
        chk("rel_mask", free_mask, 16'h0084);
        chk("reuse_7", alloc_tag, 7);
        step(1'b1, 1'b0, '0);
        chk("reuse_2", alloc_tag, 2);
        step(1'b1, 1'b0, '0);

        // Refill to 4 free, then alloc+release every cycle across the wrap
        step(1'b0, 1'b1, 4'd1);
        step(1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b1, 4'd5);
        step(1'b0, 1'b1, 4'd6);
        for (int i = 0; i < 20; i++) begin
            t = pick_used();
            step(1'b1, 1'b1, TAG_W'(t));
            chk("wrap_cnt", free_count, 4);
        end

        // Double free is sticky until reset
        async_reset("arst1");
        step(1'b0, 1'b1, 4'd9);
        chk("dfree_err", err_double_free, 1);
        chk("dfree_cnt", free_count, 12);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        chk("dfree_sticky", err_double_free, 1);

        // Randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 400; i++) begin
            logic req, ena;
            logic [TAG_W-1:0] tg;
            if (i == 200) async_reset("arst2");
            req = ($urandom_range(0, 99) < ((i % 100) < 50 ? 70 : 35));
            ena = ($urandom_range(0, 99) < 55);
            t   = pick_used();
            if (t < 0 || $urandom_range(0, 99) < 10) tg = TAG_W'($urandom_range(0, PRF_SIZE - 1));
            else tg = TAG_W'(t);
            step(req, ena, tg);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
